// File: rtl/load_store_unit_if.sv
// Request/memory bundle for load_store_unit: core request side, word-addressed
// memory port and load result/completion signals.
interface load_store_unit_if #(
  parameter int DataSize = 32,
  parameter int AddrSize = 10
);
  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [1:0]          req_size;
  logic                req_signed;
  logic [AddrSize-1:0] req_addr;
  logic [DataSize-1:0] req_wdata;
  logic                mem_enable;
  logic                mem_write;
  logic [3:0]          mem_byte_en;
  logic [AddrSize-1:0] mem_address;
  logic [DataSize-1:0] mem_write_data;
  logic                mem_ack;
  logic [DataSize-1:0] mem_rdata;
  logic [DataSize-1:0] mem_read_data;
  logic                done;
  logic                misalign;

  // Environment view: drives requests and plays the memory.
  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_ack, mem_rdata,
    input  req_ready, mem_enable, mem_write, mem_byte_en, mem_address,
    input  mem_write_data, mem_read_data, done, misalign
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_ack, mem_rdata,
    output req_ready, mem_enable, mem_write, mem_byte_en, mem_address,
    output mem_write_data, mem_read_data, done, misalign
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store sequencer: one request at a time, byte-enabled word memory port,
// aligned/extended load result. Optional misalignment trap: LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int DataSize = 32,
  parameter int AddrSize = 10
) (
  input logic             clock,
  input logic             reset,
  load_store_unit_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t              r_state, w_next;
  logic                w_accept, w_trap_req;
  logic [1:0]          r_size, r_off;
  logic                r_signed;
  logic                r_mem_write;
  logic [3:0]          r_mem_be;
  logic [AddrSize-1:0] r_mem_addr;
  logic [DataSize-1:0] r_mem_wdata, r_rd;
  logic [3:0]          w_be;
  logic [DataSize-1:0] w_wdata, w_shifted, w_load;
  logic [4:0]          w_shamt;

`ifdef LSU_MISALIGN_TRAP_EN
  logic r_misalign;
  assign w_trap_req = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                      (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));
  assign bus.misalign = r_misalign;
`else
  assign w_trap_req   = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      S_IDLE: if (bus.req_valid) begin
        w_accept = 1'b1;
        w_next   = w_trap_req ? S_DONE : S_ACCESS;
      end
      S_ACCESS: if (bus.mem_ack) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        w_be    = 4'b0001 << bus.req_addr[1:0];
        w_wdata = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend from its top bit.
  always_comb begin
    w_shamt = '0;
    case (r_size)
      2'b00:   w_shamt = {r_off, 3'b000};
      2'b01:   w_shamt = {r_off[1], 4'b0000};
      default: w_shamt = '0;
    endcase
    w_shifted = bus.mem_rdata >> w_shamt;
    case (r_size)
      2'b00:   w_load = {{(DataSize-8){r_signed & w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = {{(DataSize-16){r_signed & w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_size      <= '0;
      r_off       <= '0;
      r_signed    <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rd        <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_misalign  <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        r_size   <= bus.req_size;
        r_off    <= bus.req_addr[1:0];
        r_signed <= bus.req_signed;
        if (!w_trap_req) begin
          r_mem_write <= bus.req_write;
          r_mem_be    <= w_be;
          r_mem_addr  <= {bus.req_addr[AddrSize-1:2], 2'b00};
          r_mem_wdata <= w_wdata;
        end
`ifdef LSU_MISALIGN_TRAP_EN
        r_misalign <= w_trap_req;
`endif
      end
      if ((r_state == S_ACCESS) && bus.mem_ack) begin
        r_mem_write <= 1'b0;
        r_mem_be    <= '0;
        if (!r_mem_write) r_rd <= w_load;
      end
`ifdef LSU_MISALIGN_TRAP_EN
      if (r_state == S_DONE) r_misalign <= 1'b0;
`endif
    end
  end

  assign bus.req_ready      = (r_state == S_IDLE);
  assign bus.mem_enable     = (r_state == S_ACCESS);
  assign bus.done           = (r_state == S_DONE);
  assign bus.mem_write      = r_mem_write;
  assign bus.mem_byte_en    = r_mem_be;
  assign bus.mem_address    = r_mem_addr;
  assign bus.mem_write_data = r_mem_wdata;
  assign bus.mem_read_data  = r_rd;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit; inputs change and outputs are checked on
// the falling clock edge.
module tb_load_store_unit;
  logic clock;
  logic reset;
  int   n_assert;
  int   n_fail;

  load_store_unit_if #(.DataSize(32), .AddrSize(10)) bus ();

  load_store_unit #(.DataSize(32), .AddrSize(10)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic wr, input logic [1:0] sz, input logic sgn,
                         input logic [9:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sgn;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;

    repeat (2) @(negedge clock);
    reset = 1'b1;
    chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_enable", {31'd0, bus.mem_enable}, 32'd0);
    chk("rst_write", {31'd0, bus.mem_write}, 32'd0);
    chk("rst_be", {28'd0, bus.mem_byte_en}, 32'd0);
    chk("rst_addr", {22'd0, bus.mem_address}, 32'd0);
    chk("rst_wdata", bus.mem_write_data, 32'd0);
    chk("rst_rdata", bus.mem_read_data, 32'd0);
    chk("rst_done_mis", {30'd0, bus.done, bus.misalign}, 32'd0);

    // Word store 0x104, ack already high (ignored in IDLE, taken in ACCESS)
    @(negedge clock);
    request(1'b1, 2'b10, 1'b0, 10'h104, 32'hDEADBEEF);
    bus.mem_ack = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("ws_enable", {31'd0, bus.mem_enable}, 32'd1);
    chk("ws_addr", {22'd0, bus.mem_address}, 32'h104);
    chk("ws_be", {28'd0, bus.mem_byte_en}, 32'hF);
    chk("ws_write", {31'd0, bus.mem_write}, 32'd1);
    chk("ws_wdata", bus.mem_write_data, 32'hDEADBEEF);
    chk("ws_done_early", {31'd0, bus.done}, 32'd0);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    request(1'b0, 2'b10, 1'b0, 10'h000, 32'd0);
    chk("ws_done", {31'd0, bus.done}, 32'd1);
    chk("ws_enable_off", {31'd0, bus.mem_enable}, 32'd0);
    chk("ws_be_off", {28'd0, bus.mem_byte_en}, 32'd0);
    chk("ws_write_off", {31'd0, bus.mem_write}, 32'd0);
    chk("ws_ready_in_done", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("ws_ready_again", {31'd0, bus.req_ready}, 32'd1);
    chk("ws_done_once", {31'd0, bus.done}, 32'd0);

    // Signed byte load 0x103
    request(1'b0, 2'b00, 1'b1, 10'h103, 32'd0);
    bus.mem_rdata = 32'h80FF_0011;
    bus.mem_ack   = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("lbs_be", {28'd0, bus.mem_byte_en}, 32'h8);
    chk("lbs_addr", {22'd0, bus.mem_address}, 32'h100);
    chk("lbs_write", {31'd0, bus.mem_write}, 32'd0);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("lbs_done", {31'd0, bus.done}, 32'd1);
    chk("lbs_data", bus.mem_read_data, 32'hFFFF_FF80);
    @(negedge clock);

    // Unsigned byte load, same address
    request(1'b0, 2'b00, 1'b0, 10'h103, 32'd0);
    bus.mem_ack = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("lbu_data", bus.mem_read_data, 32'h0000_0080);
    @(negedge clock);

    // Half store 0x002 with three wait cycles
    request(1'b1, 2'b01, 1'b0, 10'h002, 32'h0000_1234);
    @(negedge clock);
    bus.req_valid = 1'b0;
    request(1'b0, 2'b10, 1'b0, 10'h3FC, 32'hFFFF_FFFF);
    bus.req_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (i == 3) bus.mem_ack = 1'b1;
      chk("hs_enable", {31'd0, bus.mem_enable}, 32'd1);
      chk("hs_be", {28'd0, bus.mem_byte_en}, 32'hC);
      chk("hs_wdata", bus.mem_write_data, 32'h1234_1234);
      chk("hs_addr", {22'd0, bus.mem_address}, 32'h000);
      chk("hs_done_early", {31'd0, bus.done}, 32'd0);
      @(negedge clock);
    end
    bus.mem_ack = 1'b0;
    chk("hs_done", {31'd0, bus.done}, 32'd1);
    chk("hs_rdata_held", bus.mem_read_data, 32'h0000_0080);
    @(negedge clock);

    // Reset during ACCESS
    request(1'b0, 2'b10, 1'b0, 10'h000, 32'd0);
    bus.mem_rdata = 32'hAAAA_5555;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("ra_enable", {31'd0, bus.mem_enable}, 32'd1);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("ra_enable_drop", {31'd0, bus.mem_enable}, 32'd0);
    chk("ra_no_done", {31'd0, bus.done}, 32'd0);
    chk("ra_rdata_clr", bus.mem_read_data, 32'd0);
    @(negedge clock);
    chk("ra_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("ra_no_done2", {31'd0, bus.done}, 32'd0);

    // Signed half load 0x006 after reset
    request(1'b0, 2'b01, 1'b1, 10'h006, 32'd0);
    bus.mem_rdata = 32'h8001_7FFF;
    bus.mem_ack   = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("lhs_be", {28'd0, bus.mem_byte_en}, 32'hC);
    chk("lhs_addr", {22'd0, bus.mem_address}, 32'h004);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("lhs_done", {31'd0, bus.done}, 32'd1);
    chk("lhs_data", bus.mem_read_data, 32'hFFFF_8001);
    @(negedge clock);

    // Size 11 behaves as word
    request(1'b0, 2'b11, 1'b1, 10'h108, 32'd0);
    bus.mem_rdata = 32'h8234_5678;
    bus.mem_ack   = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
    chk("lw11_be", {28'd0, bus.mem_byte_en}, 32'hF);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("lw11_data", bus.mem_read_data, 32'h8234_5678);
    @(negedge clock);

    // Misaligned word load 0x002
    request(1'b0, 2'b10, 1'b0, 10'h002, 32'd0);
    bus.mem_rdata = 32'h0BAD_F00D;
    bus.mem_ack   = 1'b1;
    @(negedge clock);
    bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_done", {31'd0, bus.done}, 32'd1);
    chk("mis_flag", {31'd0, bus.misalign}, 32'd1);
    chk("mis_enable", {31'd0, bus.mem_enable}, 32'd0);
    chk("mis_rdata_held", bus.mem_read_data, 32'h8234_5678);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("mis_flag_clr", {31'd0, bus.misalign}, 32'd0);
    chk("mis_ready", {31'd0, bus.req_ready}, 32'd1);
`else
    chk("mis_enable", {31'd0, bus.mem_enable}, 32'd1);
    chk("mis_addr", {22'd0, bus.mem_address}, 32'h000);
    chk("mis_be", {28'd0, bus.mem_byte_en}, 32'hF);
    @(negedge clock);
    bus.mem_ack = 1'b0;
    chk("mis_done", {31'd0, bus.done}, 32'd1);
    chk("mis_flag", {31'd0, bus.misalign}, 32'd0);
    chk("mis_data", bus.mem_read_data, 32'h0BAD_F00D);
`endif
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
